fetch_sequencer: RTL and testbench

Control sequencer for the Basic Computer's 12-bit address register (AR) and program counter (PC). It steps through the instruction fetch, decode and indirect-address cycle. It emits one-hot load/inc/clr commands to the AR and PC register instances, plus memory-read and instruction-register strobes. It then hands the cycle to the execute unit and waits for its completion handshake. It sits between the top-level control unit and the AR/PC/IR datapath registers.

---
 rtl/basc_pkg.sv | 25 ++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/basc_pkg.sv
// Shared encodings for the Basic Computer fetch/decode control path.
// State codes, AR load-source selects and the register/IO opcode.
package basc_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_T0   = 3'd2;
    localparam logic [2:0] ST_T1   = 3'd3;
    localparam logic [2:0] ST_T2   = 3'd4;
    localparam logic [2:0] ST_T3   = 3'd5;
    localparam logic [2:0] ST_EXEC = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    localparam logic [1:0] AR_SEL_PC  = 2'd0;
    localparam logic [1:0] AR_SEL_IR  = 2'd1;
    localparam logic [1:0] AR_SEL_MEM = 2'd2;

    localparam logic [2:0] OPC_REGIO = 3'b111;

    // Takes IR[15:12]: the indirect bit only matters for memory-reference opcodes.
    function automatic logic is_indirect(input logic [3:0] ir_hi);
        return ir_hi[3] && (ir_hi[2:0] != OPC_REGIO);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch / decode / indirect sequencer driving AR, PC and IR commands,
// then handing each instruction to the execute unit with a timeout guard.
module fetch_sequencer
    import basc_pkg::*;
#(
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clr_on_start,
    input  logic        halt_req,
    input  logic [15:0] ir_in,
    input  logic        exec_done,
    output logic        ar_load,
    output logic        ar_inc,
    output logic        ar_clr,
    output logic [1:0]  ar_sel,
    output logic        pc_inc,
    output logic        pc_clr,
    output logic        ir_load,
    output logic        mem_rd,
    output logic        exec_start,
    output logic [2:0]  sc,
    output logic        running,
    output logic        fault
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(EXEC_TIMEOUT - 1);

    logic       rst_ok_q;
    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic       timeout_hit;

    // The address field feeds the AR datapath directly, not this controller.
    logic unused_ir_addr;
    assign unused_ir_addr = ^ir_in[11:0];

    // Release is synchronised: the first edge after rst_n rises only arms the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_ok_q <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            fault_q  <= 1'b0;
        end else begin
            rst_ok_q <= 1'b1;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    assign timeout_hit = (state_q == ST_EXEC) && !exec_done && (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = clr_on_start ? ST_CLR : ST_T0;
            ST_CLR:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = is_indirect(ir_in[15:12]) ? ST_T3 : ST_EXEC;
            ST_T3:   state_d = ST_EXEC;
            ST_EXEC: begin
                if (exec_done)        state_d = halt_req ? ST_HALT : ST_T0;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_HALT: if (start) state_d = ST_T0;
            default: state_d = ST_IDLE;
        endcase
        if (!rst_ok_q) state_d = state_q;
    end

    // Counter is zero on every EXEC entry because it is held clear outside EXEC.
    always_comb begin
        cnt_d   = (state_q == ST_EXEC) ? cnt_q + 8'd1 : 8'd0;
        fault_d = fault_q | timeout_hit;
    end

    always_comb begin
        ar_load    = 1'b0;
        ar_clr     = 1'b0;
        ar_sel     = AR_SEL_PC;
        pc_inc     = 1'b0;
        pc_clr     = 1'b0;
        ir_load    = 1'b0;
        mem_rd     = 1'b0;
        exec_start = 1'b0;
        sc         = 3'd0;
        case (state_q)
            ST_CLR: begin
                ar_clr = 1'b1;
                pc_clr = 1'b1;
            end
            ST_T0: begin
                ar_load = 1'b1;
                ar_sel  = AR_SEL_PC;
            end
            ST_T1: begin
                mem_rd  = 1'b1;
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                sc      = 3'd1;
            end
            ST_T2: begin
                ar_load = 1'b1;
                ar_sel  = AR_SEL_IR;
                sc      = 3'd2;
            end
            ST_T3: begin
                mem_rd  = 1'b1;
                ar_load = 1'b1;
                ar_sel  = AR_SEL_MEM;
                sc      = 3'd3;
            end
            ST_EXEC: begin
                exec_start = (cnt_q == 8'd0);
                sc         = 3'd4;
            end
            default: ;
        endcase
    end

    // The AR register reads load&inc as a zero load, so increment is never issued.
    assign ar_inc  = 1'b0;
    assign running = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign fault   = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a phase-level model plus AR/PC/memory
// models is compared every cycle, with literal expectations per instruction.
module tb_fetch_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n, start, clr_on_start, halt_req, exec_done;
    logic [15:0] ir_in;
    logic        ar_load, ar_inc, ar_clr, pc_inc, pc_clr, ir_load, mem_rd, exec_start;
    logic        running, fault;
    logic [1:0]  ar_sel;
    logic [2:0]  sc;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.EXEC_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_on_start(clr_on_start),
        .halt_req(halt_req), .ir_in(ir_in), .exec_done(exec_done),
        .ar_load(ar_load), .ar_inc(ar_inc), .ar_clr(ar_clr), .ar_sel(ar_sel),
        .pc_inc(pc_inc), .pc_clr(pc_clr), .ir_load(ir_load), .mem_rd(mem_rd),
        .exec_start(exec_start), .sc(sc), .running(running), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [14:0] dut_vec;
    assign dut_vec = {ar_load, ar_inc, ar_clr, ar_sel, pc_inc, pc_clr, ir_load,
                      mem_rd, exec_start, sc, running, fault};

    // Memory contents used for indirect pointers: low 12 bits of M[a].
    function automatic logic [11:0] mem_lo(input logic [11:0] a);
        return a ^ 12'h5A5;
    endfunction

    // Datapath registers driven by the DUT commands (not reset by rst_n).
    logic [11:0] ar_m = 12'h3C0;
    logic [11:0] pc_m = 12'h3C0;
    logic [11:0] exp_pc = 12'h000;

    always @(posedge clk) begin
        if (ar_clr) ar_m <= 12'h000;
        else if (ar_load) begin
            case (ar_sel)
                2'd0:    ar_m <= pc_m;
                2'd1:    ar_m <= ir_in[11:0];
                2'd2:    ar_m <= mem_lo(ar_m);
                default: ar_m <= 12'hxxx;
            endcase
        end
        if (pc_clr) pc_m <= 12'h000;
        else if (pc_inc) pc_m <= pc_m + 12'h001;
    end

    // Phase-level behavioural model of the instruction cycle.
    typedef enum int {M_IDLE, M_CLR, M_F0, M_F1, M_F2, M_IND, M_EXE, M_HALT} mph_t;
    mph_t mph;
    bit   marmed;
    int   mexec;
    bit   mfault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mph <= M_IDLE; marmed <= 1'b0; mexec <= 0; mfault <= 1'b0;
        end else if (!marmed) begin
            marmed <= 1'b1;
        end else begin
            case (mph)
                M_IDLE: if (start) mph <= clr_on_start ? M_CLR : M_F0;
                M_CLR:  mph <= M_F0;
                M_F0:   mph <= M_F1;
                M_F1:   mph <= M_F2;
                M_F2: begin
                    mexec <= 0;
                    mph   <= (ir_in[15] && ir_in[14:12] != 3'b111) ? M_IND : M_EXE;
                end
                M_IND: begin mexec <= 0; mph <= M_EXE; end
                M_EXE: begin
                    if (exec_done) mph <= halt_req ? M_HALT : M_F0;
                    else if (mexec + 1 >= TO) begin mph <= M_HALT; mfault <= 1'b1; end
                    else mexec <= mexec + 1;
                end
                M_HALT: if (start) mph <= M_F0;
                default: mph <= M_IDLE;
            endcase
        end
    end

    function automatic logic [14:0] model_out(input mph_t p, input int ex, input bit f);
        logic al, ac, pi, pcl, il, mr, es, run;
        logic [1:0] sel;
        logic [2:0] s;
        al = 0; ac = 0; pi = 0; pcl = 0; il = 0; mr = 0; es = 0; sel = 2'd0; s = 3'd0;
        run = !(p == M_IDLE || p == M_HALT);
        case (p)
            M_CLR: begin ac = 1; pcl = 1; end
            M_F0:  al = 1;
            M_F1:  begin mr = 1; il = 1; pi = 1; s = 3'd1; end
            M_F2:  begin al = 1; sel = 2'd1; s = 3'd2; end
            M_IND: begin mr = 1; al = 1; sel = 2'd2; s = 3'd3; end
            M_EXE: begin es = (ex == 0); s = 3'd4; end
            default: ;
        endcase
        return {al, 1'b0, ac, sel, pi, pcl, il, mr, es, s, run, f};
    endfunction

    logic [14:0] exp_vec;
    always @(negedge clk) begin
        exp_vec = rst_n ? model_out(mph, mexec, mfault) : 15'd0;
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: got %b required %b", $time, dut_vec, exp_vec);
        end
        checks++;
        if ((int'(ar_load) + int'(ar_inc) + int'(ar_clr)) > 1 || (pc_inc && pc_clr)) begin
            errors++;
            $display("FAIL cmd_exclusive t=%0t: ar=%b%b%b pc_inc=%b pc_clr=%b required one-hot",
                     $time, ar_load, ar_inc, ar_clr, pc_inc, pc_clr);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    // One instruction: optional start, fetch until exec_start, then complete or time out.
    task automatic run_instr(input logic [15:0] ir, input bit do_start, input bit clr,
                             input int exp_lat, input bit exp_t3, input int done_after,
                             input bit halt, output logic [31:0] trace);
        int n, m, ex_cycles;
        bit got, saw3, sawclr;
        logic [11:0] exp_ar;
        n = 0; got = 0; saw3 = 0; sawclr = 0; trace = 32'd0;
        exp_ar = (ir[15] && ir[14:12] != 3'b111) ? mem_lo(ir[11:0]) : ir[11:0];
        ir_in = ir; start = do_start; clr_on_start = clr;
        if (clr) exp_pc = 12'h000;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            start = 1'b0; clr_on_start = 1'b0; n++;
            trace = (trace << 3) | 32'(sc);
            if (sc == 3'd3) saw3 = 1;
            if (ar_clr || pc_clr) sawclr = 1;
            if (exec_start) got = 1;
        end
        exp_pc = exp_pc + 12'h001;
        check("exec_start_seen", 32'(got), 32'd1);
        check("fetch_latency", n, exp_lat);
        check("indirect_visit", 32'(saw3), 32'(exp_t3));
        check("clear_issued", 32'(sawclr), 32'(clr));
        check("ar_at_exec", 32'(ar_m), 32'(exp_ar));
        check("pc_at_exec", 32'(pc_m), 32'(exp_pc));
        $display("instr ir=%h start=%0d clr=%0d latency=%0d ar=%h pc=%h", ir, do_start, clr, n, ar_m, pc_m);
        if (done_after < 0) begin
            ex_cycles = 1; m = 0;
            while (running && m < 40) begin
                @(posedge clk); #1; m++;
                if (running && sc == 3'd4) ex_cycles++;
            end
            check("timeout_cycles", ex_cycles, TO);
            check("timeout_fault", 32'(fault), 32'd1);
            check("timeout_halted", 32'(running), 32'd0);
        end else begin
            repeat (done_after) begin
                halt_req = 1'b1;
                @(posedge clk); #1;
            end
            exec_done = 1'b1; halt_req = halt;
            @(posedge clk); #1;
            exec_done = 1'b0; halt_req = 1'b0;
        end
    endtask

    logic [31:0] tr;

    initial begin
        rst_n = 1'b0; start = 1'b0; clr_on_start = 1'b0; halt_req = 1'b0;
        exec_done = 1'b0; ir_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(dut_vec), 32'd0);

        // First edge after release only arms the sequencer.
        rst_n = 1'b1; start = 1'b1; clr_on_start = 1'b1;
        @(posedge clk); #1;
        check("first_edge_ignored", 32'(running), 32'd0);

        run_instr(16'h2005, 1, 1, 5, 0, 2, 0, tr);
        check("sc_trace_direct_clr", tr, 32'h54);

        run_instr(16'hF800, 0, 0, 3, 0, 3, 1, tr);
        check("sc_trace_regio", tr, 32'h54);
        check("halt_running", 32'(running), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("halt_holds", 32'(running), 32'd0);

        run_instr(16'hA00F, 1, 0, 5, 1, 0, 1, tr);
        check("sc_trace_indirect", tr, 32'h29C);
        check("indirect_ar_literal", 32'(ar_m), 32'h5AA);
        check("pc_literal", 32'(pc_m), 32'd3);

        run_instr(16'h1234, 1, 0, 4, 0, -1, 0, tr);

        run_instr(16'h8ABC, 1, 0, 5, 1, 1, 0, tr);
        check("fault_sticky", 32'(fault), 32'd1);
        check("indirect_ar_literal2", 32'(ar_m), 32'hF19);

        // Abort mid-T1: outputs drop before any clock edge, PC increment is lost.
        @(posedge clk); #1;
        check("in_t1", 32'(sc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_vec), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("pc_after_abort", 32'(pc_m), 32'd5);
        check("fault_cleared", 32'(fault), 32'd0);
        @(posedge clk); #1;

        run_instr(16'h2005, 1, 1, 5, 0, 0, 1, tr);
        check("final_halt", 32'(running), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish before 100000");
        $fatal(1);
    end

endmodule
